// File: rtl/mecobo_pkg.sv
// Shared command-path constants and the assembler state encoding.
package mecobo_pkg;
  localparam int CMD_W      = 80;
  localparam int EBI_WORD_W = 16;
  localparam int CMD_WORDS  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } asm_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear.
// Latency: count visible the cycle after inc. No backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ebi_cmd_assembler.sv
// Packs WORDS EBI words (word 0 in the MSBs) into one command_fifo push.
// Latency: push 1 cycle after the last word. Backpressure: HOLD while fifo_full; words arriving then are dropped.
// Partial commands idle for TIMEOUT_CYCLES are discarded; sync_clear discards everything in flight.
module ebi_cmd_assembler
  import mecobo_pkg::*;
#(
  parameter int WORDS          = CMD_WORDS,
  parameter int WORD_W         = EBI_WORD_W,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    word_wr,
  input  logic [WORD_W-1:0]       word_data,
  input  logic                    sync_clear,
  output logic [WORDS*WORD_W-1:0] fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  output logic                    accept_ready,
  output logic [2:0]              word_index,
  output logic [15:0]             cmd_count,
  output logic [ERR_CNT_W-1:0]    drop_count,
  output logic [ERR_CNT_W-1:0]    timeout_count
);

  localparam int CMD_BITS = WORDS * WORD_W;
  localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  asm_state_t       state;
  logic [TMO_W-1:0] idle_cnt;
  logic             drop_inc;
  logic             tmo_hit;

  assign accept_ready = (state != HOLD);
  // Push is gated by the live full flag so a push never lands on a full FIFO.
  assign fifo_wr_en   = (state == HOLD) && !fifo_full && !sync_clear;
  assign drop_inc     = word_wr && !accept_ready && !sync_clear;
  assign tmo_hit      = (state == COLLECT) && !word_wr && !sync_clear &&
                        (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_index <= '0;
      idle_cnt   <= '0;
      fifo_din   <= '0;
      cmd_count  <= '0;
    end else if (sync_clear) begin
      state      <= IDLE;
      word_index <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (word_wr) begin
            fifo_din[CMD_BITS-1-WORD_W*int'(word_index) -: WORD_W] <= word_data;
            idle_cnt <= '0;
            if (word_index == 3'(WORDS - 1)) begin
              state      <= HOLD;
              word_index <= '0;
            end else begin
              state      <= COLLECT;
              word_index <= word_index + 3'd1;
            end
          end else if (tmo_hit) begin
            state      <= IDLE;
            word_index <= '0;
            idle_cnt   <= '0;
          end else if (state == COLLECT) begin
            idle_cnt <= idle_cnt + TMO_W'(1);
          end
        end
        HOLD: begin
          if (!fifo_full) begin
            state     <= IDLE;
            cmd_count <= cmd_count + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          word_index <= '0;
          idle_cnt   <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .clear (1'b0),
    .cnt   (drop_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tmo_hit),
    .clear (1'b0),
    .cnt   (timeout_count)
  );

endmodule

// File: tb/tb_ebi_cmd_assembler.sv
// Bench for ebi_cmd_assembler: directed scenarios plus random traffic against a queue-based model.
module tb_ebi_cmd_assembler;
  localparam int TMO     = 16;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst;
  logic             word_wr;
  logic [15:0]      word_data;
  logic             sync_clear;
  logic [79:0]      fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic             accept_ready;
  logic [2:0]       word_index;
  logic [15:0]      cmd_count;
  logic [ERR_W-1:0] drop_count;
  logic [ERR_W-1:0] timeout_count;

  ebi_cmd_assembler #(
    .WORDS(5), .WORD_W(16), .TIMEOUT_CYCLES(TMO), .ERR_CNT_W(ERR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .word_wr       (word_wr),
    .word_data     (word_data),
    .sync_clear    (sync_clear),
    .fifo_din      (fifo_din),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .accept_ready  (accept_ready),
    .word_index    (word_index),
    .cmd_count     (cmd_count),
    .drop_count    (drop_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words of the current command in a queue, plus one held command.
  bit          m_held = 1'b0;
  logic [79:0] m_dat  = '0;
  logic [15:0] m_q[$];
  int          m_idle = 0;
  logic [15:0] m_cmd  = '0;
  int          m_drop = 0;
  int          m_tmo  = 0;

  task automatic m_reset();
    m_held = 1'b0;
    m_q.delete();
    m_idle = 0;
    m_cmd  = '0;
    m_drop = 0;
    m_tmo  = 0;
  endtask

  task automatic m_step();
    if (sync_clear) begin
      m_q.delete();
      m_held = 1'b0;
      m_idle = 0;
    end else if (m_held) begin
      if (word_wr && m_drop < ERR_MAX) m_drop++;
      if (!fifo_full) begin
        m_held = 1'b0;
        m_cmd  = m_cmd + 16'd1;
      end
    end else if (word_wr) begin
      m_q.push_back(word_data);
      m_idle = 0;
      if (m_q.size() == 5) begin
        m_dat = '0;
        foreach (m_q[k]) m_dat = {m_dat[63:0], m_q[k]};
        m_held = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() != 0) begin
      if (m_idle == TMO - 1) begin
        m_q.delete();
        m_idle = 0;
        if (m_tmo < ERR_MAX) m_tmo++;
      end else begin
        m_idle++;
      end
    end
  endtask

  // Compare process: outputs checked mid-cycle, then the model advances over the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_reset();
      chk("fifo_din_rst", fifo_din, 80'h0);
    end
    n_vec++;
    chk("accept_ready", 80'(accept_ready), 80'(!m_held));
    chk("fifo_wr_en", 80'(fifo_wr_en), 80'(m_held && !fifo_full && !sync_clear && rst));
    chk("word_index", 80'(word_index), 80'(m_q.size()));
    chk("cmd_count", 80'(cmd_count), 80'(m_cmd));
    chk("drop_count", 80'(drop_count), 80'(m_drop));
    chk("timeout_count", 80'(timeout_count), 80'(m_tmo));
    if (m_held) chk("fifo_din", fifo_din, m_dat);
    if (rst) m_step();
  end

  task automatic set_in(input bit wr, input logic [15:0] d, input bit full, input bit clr);
    word_wr    = wr;
    word_data  = d;
    fifo_full  = full;
    sync_clear = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    set_in(0, 16'h0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Words are base*1 .. base*5; ends on the first HOLD cycle with inputs idle.
  task automatic send_words(input int n, input logic [15:0] base, input bit full);
    for (int k = 0; k < n; k++) begin
      set_in(1, 16'(base * (k + 1)), full, 0);
      tick();
    end
    set_in(0, 16'h0, full, 0);
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 80'(accept_ready), 80'h1);
    chk("rst_wr_en", 80'(fifo_wr_en), 80'h0);
    chk("rst_index", 80'(word_index), 80'h0);
    chk("rst_cmd", 80'(cmd_count), 80'h0);
    chk("rst_din", fifo_din, 80'h0);

    // Basic command, FIFO ready
    send_words(5, 16'h1111, 0);
    #1;
    chk("t1_push", 80'(fifo_wr_en), 80'h1);
    chk("t1_din", fifo_din, 80'h11112222333344445555);
    chk("t1_ready", 80'(accept_ready), 80'h0);
    tick();
    chk("t1_cmd", 80'(cmd_count), 80'h1);
    chk("t1_nopush", 80'(fifo_wr_en), 80'h0);

    // FIFO full for 10 cycles with three words arriving during HOLD
    do_reset();
    send_words(5, 16'h1111, 1);
    for (int i = 0; i < 10; i++) begin
      set_in(i == 2 || i == 5 || i == 8, 16'hdead, 1, 0);
      #1;
      chk("t2_hold_nopush", 80'(fifo_wr_en), 80'h0);
      tick();
    end
    set_in(0, 16'h0, 0, 0);
    #1;
    chk("t2_push", 80'(fifo_wr_en), 80'h1);
    chk("t2_din", fifo_din, 80'h11112222333344445555);
    chk("t2_drop", 80'(drop_count), 80'h3);
    tick();
    chk("t2_cmd", 80'(cmd_count), 80'h1);

    // Partial command timeout, then a clean command
    do_reset();
    send_words(2, 16'h0101, 0);
    repeat (15) tick();
    chk("t3_index_pre", 80'(word_index), 80'h2);
    chk("t3_tmo_pre", 80'(timeout_count), 80'h0);
    tick();
    chk("t3_index", 80'(word_index), 80'h0);
    chk("t3_tmo", 80'(timeout_count), 80'h1);
    send_words(5, 16'h1234, 0);
    #1;
    chk("t3_push", 80'(fifo_wr_en), 80'h1);
    chk("t3_din", fifo_din, 80'h12342468369C48D05B04);
    tick();

    // sync_clear in HOLD with a simultaneous word
    do_reset();
    send_words(5, 16'h0101, 0);
    set_in(1, 16'hbeef, 0, 1);
    #1;
    chk("t4_nopush", 80'(fifo_wr_en), 80'h0);
    tick();
    set_in(0, 16'h0, 0, 0);
    #1;
    chk("t4_ready", 80'(accept_ready), 80'h1);
    chk("t4_index", 80'(word_index), 80'h0);
    chk("t4_drop", 80'(drop_count), 80'h0);
    chk("t4_cmd", 80'(cmd_count), 80'h0);

    // Drop counter saturation
    send_words(5, 16'h0202, 1);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 16'h5a5a, 1, 0);
      tick();
    end
    set_in(0, 16'h0, 1, 0);
    #1;
    chk("t5_drop_sat", 80'(drop_count), 80'h3);
    set_in(0, 16'h0, 0, 0);
    tick();
    chk("t5_cmd", 80'(cmd_count), 80'h1);

    // Async reset in the middle of a command
    send_words(3, 16'h0303, 0);
    #1;
    chk("t6_index_pre", 80'(word_index), 80'h3);
    rst = 1'b0;
    #1;
    chk("t6_index", 80'(word_index), 80'h0);
    chk("t6_cmd", 80'(cmd_count), 80'h0);
    chk("t6_drop", 80'(drop_count), 80'h0);
    chk("t6_din", fifo_din, 80'h0);
    tick();
    rst = 1'b1;
    send_words(5, 16'h0101, 0);
    #1;
    chk("t6_push", 80'(fifo_wr_en), 80'h1);
    chk("t6_din_after", fifo_din, 80'h01010202030304040505);
    tick();
    chk("t6_cmd_after", 80'(cmd_count), 80'h1);

    // Random traffic in segments of differing word density
    for (int seg = 0; seg < 15; seg++) begin
      int rate;
      case (seg % 3)
        0:       rate = 5;
        1:       rate = 50;
        default: rate = 90;
      endcase
      repeat (200) begin
        set_in($urandom_range(0, 99) < rate, 16'($urandom),
               $urandom_range(0, 99) < 40, $urandom_range(0, 99) == 0);
        tick();
      end
    end
    set_in(0, 16'h0, 0, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ebi_cmd_assembler.md
Name: ebi_cmd_assembler

Overview:
- Sits between the ebi block and command_fifo.
- Collects five consecutive 16-bit EBI command words into one 80-bit scheduler command and pushes it into command_fifo with a single-cycle write.
- Provides backpressure, a partial-command timeout and error counters so the host can detect dropped or stale words.

Parameters:
- WORDS, 5, words per command.
- WORD_W, 16, EBI word width.
- TIMEOUT_CYCLES, 65535, idle clk cycles allowed between words of a partial command before it is discarded.
- ERR_CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock (sys_clk domain).
- rst  in  1  reset, asynchronous, active-low.
- word_wr  in  1  single-cycle strobe: word_data holds a valid command word.
- word_data  in  16  command word.
- sync_clear  in  1  synchronous discard of any partial or held command (driven from softy_reset).
- fifo_din  out  80  assembled command to command_fifo.
- fifo_wr_en  out  1  single-cycle push to command_fifo.
- fifo_full  in  1  command_fifo full flag.
- accept_ready  out  1  1 when the next word_wr will be accepted.
- word_index  out  3  number of words collected in the current command, 0..4.
- cmd_count  out  16  commands pushed, wraps at 2^16.
- drop_count  out  ERR_CNT_W  words rejected while not ready, saturating.
- timeout_count  out  ERR_CNT_W  partial commands discarded by timeout, saturating.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs and counters 0; accept_ready=1 after release.
- Word packing: word k (k=0..4) goes to fifo_din[79-16k -: 16], so word 0 is the MSBs.
- States:
  - IDLE: index 0.
  - COLLECT: index 1..4.
  - HOLD: full command registered, waiting for FIFO space.
- IDLE + word_wr: store word 0, index=1, go to COLLECT.
- COLLECT + word_wr: store word at index, index+1. On the 5th word, go to HOLD and set index=0.
- HOLD:
  - If fifo_full=0: fifo_wr_en=1 for exactly one cycle, cmd_count+1, go to IDLE.
  - If fifo_full=1: stay in HOLD; fifo_din stays stable.
  - Latency: the earliest push is 1 cycle after the 5th word_wr cycle.
- accept_ready = (state != HOLD), combinational from the registered state. It is 0 during the push cycle.
- word_wr while accept_ready=0: word ignored, drop_count+1, saturating at all-ones.
- Timeout:
  - The idle counter clears on every accepted word and counts only in COLLECT.
  - When it reaches TIMEOUT_CYCLES-1 with no word_wr that cycle: discard the partial command, index=0, go to IDLE, timeout_count+1 (saturating).
  - If word_wr arrives in that same cycle, the word wins and there is no timeout.
- sync_clear has highest priority:
  - Next state IDLE, index 0, no push that cycle even if in HOLD with fifo_full=0.
  - A simultaneous word_wr is discarded and is not counted as a drop.
  - All counters are retained.
- fifo_din is a register. It is only meaningful when fifo_wr_en=1 and holds its last value otherwise.
- fifo_wr_en is never asserted while fifo_full=1.
- Counters never wrap except cmd_count.

Decomposition:
- Shared package (mecobo_pkg) holds: CMD_W=80, EBI_WORD_W=16, CMD_WORDS=5, state encoding constants (IDLE/COLLECT/HOLD).
- One natural sub-module: sat_counter (parameterised width, inc, clear, saturating), instantiated twice for drop_count and timeout_count.

Test Plan:
- Five word_wr of 0x1111,0x2222,0x3333,0x4444,0x5555 with fifo_full=0 -> one fifo_wr_en pulse 1 cycle after the 5th word, fifo_din=0x11112222333344445555, cmd_count=1.
- Same sequence with fifo_full=1 held 10 cycles, plus 3 word_wr during HOLD -> no push while full; push the cycle after full drops; drop_count=3; fifo_din unchanged.
- TIMEOUT_CYCLES=16: 2 words, then silence -> IDLE after 16 idle cycles, timeout_count=1, word_index=0. Next 5 words produce a clean command.
- sync_clear asserted in HOLD (fifo_full=0) together with word_wr -> no push, IDLE, drop_count unchanged, cmd_count unchanged.
- ERR_CNT_W=2: 5 drops -> drop_count saturates at 3.
- Assert rst mid-COLLECT (index=3) -> outputs 0 immediately (async). After release, 5 words give exactly one correct command.
